// File: rtl/ram_dp_arb.sv
// Round-robin arbiter sharing port A of a dual-port RAM among Req_Num requesters,
// with optional burst locking and a one-cycle registered read-valid return.
module ram_dp_arb #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int Req_Num    = 3,
  parameter int Max_Burst  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Req_Num-1:0]           req_i,
  input  logic [Req_Num-1:0]           wen_i,
  input  logic [Req_Num-1:0]           lock_i,
  input  logic [Req_Num*Addr_Width-1:0] addr_i,
  input  logic [Req_Num*Word_Width-1:0] data_i,
  output logic [Req_Num-1:0]           gnt_o,
  output logic [Req_Num-1:0]           rd_val_o,
  output logic [Word_Width-1:0]        rd_data_o,
  output logic                         ram_cen_o,
  output logic                         ram_wen_o,
  output logic                         ram_oen_o,
  output logic [Addr_Width-1:0]        ram_addr_o,
  output logic [Word_Width-1:0]        ram_data_o,
  input  logic [Word_Width-1:0]        ram_data_i
);

  localparam int              IdxW     = (Req_Num > 1) ? $clog2(Req_Num) : 1;
  localparam logic [IdxW-1:0] LastRst  = IdxW'(Req_Num - 1);
  localparam logic [3:0]      BurstMax = 4'(Max_Burst);

  logic [IdxW-1:0]    last_q, last_d;
  logic               hold_q, hold_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [Req_Num-1:0] rdv_q, rdv_d;

  logic [IdxW-1:0] gidx;
  logic            gvld;
  logic            locked;
  logic [3:0]      cnt_n;

  // Grant decision: the locked owner keeps the port only while it still requests.
  always_comb begin
    gidx   = last_q;
    gvld   = 1'b0;
    locked = 1'b0;
    if (!rst) begin
      if (hold_q && req_i[last_q]) begin
        gvld   = 1'b1;
        locked = 1'b1;
      end else begin
        for (int i = 1; i <= Req_Num; i++) begin
          if (!gvld && req_i[(int'(last_q) + i) % Req_Num]) begin
            gvld = 1'b1;
            gidx = IdxW'((int'(last_q) + i) % Req_Num);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gvld) gnt_o[gidx] = 1'b1;
  end

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (gvld) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = wen_i[gidx];
      ram_addr_o = addr_i[int'(gidx)*Addr_Width +: Addr_Width];
      ram_data_o = data_i[int'(gidx)*Word_Width +: Word_Width];
    end
  end

  assign ram_oen_o = 1'b0;

  // Burst bookkeeping: the count restarts at 1 on any non-locked grant.
  always_comb begin
    cnt_n  = locked ? (cnt_q + 4'd1) : 4'd1;
    last_d = last_q;
    hold_d = 1'b0;
    cnt_d  = 4'd0;
    if (gvld) begin
      last_d = gidx;
      cnt_d  = cnt_n;
      hold_d = lock_i[gidx] && (cnt_n < BurstMax);
    end
    rdv_d = gnt_o & wen_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LastRst;
      hold_q <= 1'b0;
      cnt_q  <= 4'd0;
      rdv_q  <= '0;
    end else begin
      last_q <= last_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      rdv_q  <= rdv_d;
    end
  end

  // RAM read data arrives one cycle after the grant, aligned with rdv_q.
  assign rd_val_o  = rdv_q;
  assign rd_data_o = ram_data_i;

endmodule
